// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: load-use stall, redirect flush,
// registered forwarding selects and saturating event counters.
module ex_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_id_valid,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_ex_valid,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_RegWrite,
   input  logic             i_ex_MemRead,
   input  logic             i_mem_valid,
   input  logic [4:0]       i_mem_rd,
   input  logic             i_mem_RegWrite,
   input  logic             i_branch,
   input  logic             i_jmp,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic             o_stall,
   output logic             o_flush_id,
   output logic             o_flush_ex,
   output logic             o_redirect,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

   localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nx;
   logic [2:0] fcnt, fcnt_nx;
   logic       redir_req, load_use;
   logic       ex_fw, mem_fw;
   logic [1:0] sel_a, sel_b;

   assign redir_req = i_ex_valid & (i_branch | i_jmp);
   assign load_use  = i_id_valid & i_ex_valid & i_ex_MemRead
                    & (i_ex_rd != 5'd0)
                    & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
   assign ex_fw  = i_ex_valid & i_ex_RegWrite & (i_ex_rd != 5'd0);
   assign mem_fw = i_mem_valid & i_mem_RegWrite & (i_mem_rd != 5'd0);

   // Forwarding source per operand: newest producer (EX) wins over MEM.
   always_comb begin
      sel_a = 2'd0;
      sel_b = 2'd0;
      if (ex_fw && i_ex_rd == i_id_rs1)         sel_a = 2'd1;
      else if (mem_fw && i_mem_rd == i_id_rs1)  sel_a = 2'd2;
      if (ex_fw && i_ex_rd == i_id_rs2)         sel_b = 2'd1;
      else if (mem_fw && i_mem_rd == i_id_rs2)  sel_b = 2'd2;
   end

   // Next state and control outputs; redirect beats load-use.
   always_comb begin
      state_nx   = state;
      fcnt_nx    = fcnt;
      o_redirect = 1'b0;
      o_flush_id = 1'b0;
      o_flush_ex = 1'b0;
      o_stall    = 1'b0;
      if (!i_reset) begin
         unique case (state)
            RUN: begin
               if (redir_req) begin
                  o_redirect = 1'b1;
                  o_flush_id = 1'b1;
                  o_flush_ex = 1'b1;
                  state_nx   = FLUSH;
                  fcnt_nx    = FC_INIT;
               end else if (load_use) begin
                  o_stall    = 1'b1;
                  o_flush_ex = 1'b1;
                  state_nx   = LDSTALL;
               end
            end
            LDSTALL: begin
               if (redir_req) begin
                  o_redirect = 1'b1;
                  o_flush_id = 1'b1;
                  o_flush_ex = 1'b1;
                  state_nx   = FLUSH;
                  fcnt_nx    = FC_INIT;
               end else begin
                  state_nx = RUN;
               end
            end
            FLUSH: begin
               o_flush_id = 1'b1;
               if (fcnt == 3'd0) state_nx = RUN;
               else              fcnt_nx  = fcnt - 3'd1;
            end
            default: state_nx = RUN;
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= RUN;
         fcnt  <= 3'd0;
      end else begin
         state <= state_nx;
         fcnt  <= fcnt_nx;
      end
   end

   // Forward selects: hold on stall, zero on bubble, else latch.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_fwd_a <= 2'd0;
         o_fwd_b <= 2'd0;
      end else if (o_stall) begin
         o_fwd_a <= o_fwd_a;
         o_fwd_b <= o_fwd_b;
      end else if (o_flush_ex) begin
         o_fwd_a <= 2'd0;
         o_fwd_b <= 2'd0;
      end else begin
         o_fwd_a <= sel_a;
         o_fwd_b <= sel_b;
      end
   end

   // Saturating stall and redirect event counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall && o_stall_cnt != '1)
            o_stall_cnt <= o_stall_cnt + 1'b1;
         if (o_redirect && o_flush_cnt != '1)
            o_flush_cnt <= o_flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus random
// traffic, all checked against a cycle-level reference model.
module tb_ex_hazard_ctrl;

   localparam int FC = 2;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, ex_valid, ex_rw, ex_mr;
   logic          mem_valid, mem_rw, branch, jmp;
   logic [4:0]    rs1, rs2, ex_rd, mem_rd;
   logic [1:0]    fwd_a, fwd_b;
   logic          stall, flush_id, flush_ex, redirect;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   int m_flush_left;
   bit m_ld;
   int m_fa, m_fb, m_sc, m_fc;
   bit e_redir, e_stall, e_fid, e_fex;

   always #5 clk = ~clk;

   ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_ex_valid(ex_valid), .i_ex_rd(ex_rd),
      .i_ex_RegWrite(ex_rw), .i_ex_MemRead(ex_mr),
      .i_mem_valid(mem_valid), .i_mem_rd(mem_rd),
      .i_mem_RegWrite(mem_rw),
      .i_branch(branch), .i_jmp(jmp),
      .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
      .o_stall(stall), .o_flush_id(flush_id),
      .o_flush_ex(flush_ex), .o_redirect(redirect),
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int fsel(input logic [4:0] s);
      if (ex_valid && ex_rw && ex_rd != 0 && ex_rd == s) return 1;
      if (mem_valid && mem_rw && mem_rd != 0 && mem_rd == s) return 2;
      return 0;
   endfunction

   task automatic idle();
      id_valid = 0; ex_valid = 0; ex_rw = 0; ex_mr = 0;
      mem_valid = 0; mem_rw = 0; branch = 0; jmp = 0;
      rs1 = 0; rs2 = 0; ex_rd = 0; mem_rd = 0;
   endtask

   // One clock: check combinational outputs mid-cycle, then
   // advance the model and check registered outputs after the edge.
   task automatic step();
      bit in_flush, lu;
      @(negedge clk);
      in_flush = (m_flush_left > 0);
      lu = id_valid && ex_valid && ex_mr && ex_rd != 0
           && (ex_rd == rs1 || ex_rd == rs2);
      e_redir = !rst && ex_valid && (branch || jmp) && !in_flush;
      e_stall = !rst && !in_flush && !m_ld && lu && !e_redir;
      e_fex   = e_redir || e_stall;
      e_fid   = e_redir || (!rst && in_flush);
      chk("redirect", int'(redirect), int'(e_redir));
      chk("stall",    int'(stall),    int'(e_stall));
      chk("flush_ex", int'(flush_ex), int'(e_fex));
      chk("flush_id", int'(flush_id), int'(e_fid));
      @(posedge clk);
      if (rst) begin
         m_flush_left = 0; m_ld = 0;
         m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
      end else begin
         if (e_redir)       m_flush_left = FC;
         else if (in_flush) m_flush_left--;
         m_ld = e_stall;
         if (!e_stall) begin
            if (e_fex) begin
               m_fa = 0; m_fb = 0;
            end else begin
               m_fa = fsel(rs1); m_fb = fsel(rs2);
            end
         end
         if (e_stall && m_sc < CMAX) m_sc++;
         if (e_redir && m_fc < CMAX) m_fc++;
      end
      #1;
      chk("fwd_a",     int'(fwd_a),     m_fa);
      chk("fwd_b",     int'(fwd_b),     m_fb);
      chk("stall_cnt", int'(stall_cnt), m_sc);
      chk("flush_cnt", int'(flush_cnt), m_fc);
   endtask

   initial begin
      m_flush_left = 0; m_ld = 0;
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
      idle();
      rst = 1;
      step();
      step();
      rst = 0;
      step();

      // EX producer forwards to rs1
      idle(); id_valid = 1; rs1 = 5; rs2 = 0;
      ex_valid = 1; ex_rd = 5; ex_rw = 1;
      step();
      chk("fwd_ex_a", int'(fwd_a), 1);
      chk("fwd_ex_b", int'(fwd_b), 0);

      // load-use on rs2, then MEM forwarding after the stall
      idle(); id_valid = 1; rs1 = 1; rs2 = 7;
      ex_valid = 1; ex_rd = 7; ex_rw = 1; ex_mr = 1;
      step();
      chk("lu_stall_cnt", int'(stall_cnt), 1);
      idle(); id_valid = 1; rs1 = 1; rs2 = 7;
      mem_valid = 1; mem_rd = 7; mem_rw = 1;
      step();
      chk("lu_fwd_mem_b", int'(fwd_b), 2);
      chk("lu_one_stall", int'(stall_cnt), 1);

      // jump: redirect + FLUSH_CYCLES of ID squash, branches ignored
      idle(); ex_valid = 1; jmp = 1;
      step();
      idle(); ex_valid = 1; branch = 1;
      step();
      step();
      idle();
      step();
      chk("jmp_flush_cnt", int'(flush_cnt), 1);

      // redirect outranks a simultaneous load-use
      idle(); id_valid = 1; rs1 = 9;
      ex_valid = 1; ex_rd = 9; ex_mr = 1; ex_rw = 1; branch = 1;
      step();
      chk("prio_stall_cnt", int'(stall_cnt), 1);
      chk("prio_flush_cnt", int'(flush_cnt), 2);
      idle();
      step();
      step();

      // x0 is never forwarded and never stalls
      idle(); id_valid = 1; rs1 = 0; rs2 = 0;
      ex_valid = 1; ex_rd = 0; ex_rw = 1; ex_mr = 1;
      mem_valid = 1; mem_rd = 0; mem_rw = 1;
      step();
      chk("x0_fwd_a", int'(fwd_a), 0);
      chk("x0_fwd_b", int'(fwd_b), 0);

      // reset in the second FLUSH cycle
      idle(); ex_valid = 1; jmp = 1;
      step();
      idle();
      step();
      rst = 1;
      step();
      rst = 0;
      step();
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      chk("rst_flush_cnt", int'(flush_cnt), 0);
      chk("rst_flush_id",  int'(flush_id), 0);

      // 20 stalls saturate a 4-bit counter at 15
      idle(); id_valid = 1; rs1 = 3;
      ex_valid = 1; ex_rd = 3; ex_mr = 1;
      for (int i = 0; i < 40; i++) step();
      chk("sat_stall_cnt", int'(stall_cnt), CMAX);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         id_valid  = $urandom_range(0, 1);
         rs1       = 5'($urandom_range(0, 3));
         rs2       = 5'($urandom_range(0, 3));
         ex_valid  = $urandom_range(0, 1);
         ex_rd     = 5'($urandom_range(0, 3));
         ex_rw     = $urandom_range(0, 1);
         ex_mr     = $urandom_range(0, 1);
         mem_valid = $urandom_range(0, 1);
         mem_rd    = 5'($urandom_range(0, 3));
         mem_rw    = $urandom_range(0, 1);
         branch    = ($urandom_range(0, 7) == 0);
         jmp       = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
